// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with 7-bit address match and a byte-stream RX/TX user port.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a FILT_LEN-cycle stability filter on scl/sda.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE} state_t;
  state_t     r_state;
  logic [1:0] r_scl_s, r_sda_s;
  logic       r_scl_d, r_sda_d, r_oe;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_match, w_tx;
  logic [2:0] w_cnt_n;

  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_chk
    $error("FILT_LEN must be in 1..15");
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_scl_s <= 2'b11;
      r_sda_s <= 2'b11;
    end else begin
      r_scl_s <= {r_scl_s[0], scl};
      r_sda_s <= {r_sda_s[0], sda};
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] w_raw, w_flt;
  assign w_raw = {r_scl_s[1], r_sda_s[1]};
  for (genvar i = 0; i < 2; i++) begin : g_flt
    logic       r_f;
    logic [3:0] r_c;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_f <= 1'b1;
        r_c <= 4'd0;
      end else if (w_raw[i] == r_f) r_c <= 4'd0;
      else if (r_c == 4'(FILT_LEN - 1)) begin
        r_f <= w_raw[i];
        r_c <= 4'd0;
      end else r_c <= r_c + 4'd1;
    assign w_flt[i] = r_f;
  end
  assign {w_scl, w_sda} = w_flt;
`else
  assign w_scl = r_scl_s[1];
  assign w_sda = r_sda_s[1];
`endif

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_match    = r_shift[6:0] == SLAVE_ADDR;
  assign w_tx       = (r_state == ADDR_ACK) & rw;
  assign w_cnt_n    = r_cnt + 3'd1;
  assign sda        = r_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= IDLE;
      r_scl_d  <= 1'b1;
      r_sda_d  <= 1'b1;
      r_oe     <= 1'b0;
      r_cnt    <= 3'd0;
      r_shift  <= 8'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_scl_d  <= w_scl;
      r_sda_d  <= w_sda;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      done     <= 1'b0;
      if (w_stop) begin
        r_state <= IDLE;
        r_oe    <= 1'b0;
        busy    <= 1'b0;
        done    <= busy;
      end else if (w_start) begin
        r_state <= ADDR;
        r_cnt   <= 3'd0;
        r_oe    <= 1'b0;
      end else case (r_state)
        ADDR:
          if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            r_cnt   <= w_cnt_n;
            if (r_cnt == 3'd7) begin
              r_state <= w_match ? ADDR_ACK : IGNORE;
              busy    <= w_match;
              rw      <= w_match ? w_sda : rw;
            end
          end
        // First scl_fall starts driving the ACK, the second ends the ACK bit
        ADDR_ACK, RX_ACK: begin
          tx_req <= w_scl_rise & r_oe & w_tx;
          if (w_scl_fall && !r_oe) r_oe <= 1'b1;
          else if (w_scl_fall) begin
            r_state <= w_tx ? TX_BYTE : RX_BYTE;
            r_shift <= tx_data;
            r_oe    <= w_tx & ~tx_data[7];
          end
        end
        RX_BYTE:
          if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], w_sda};
            r_cnt   <= w_cnt_n;
            if (r_cnt == 3'd7) begin
              rx_data  <= {r_shift[6:0], w_sda};
              rx_valid <= 1'b1;
              r_state  <= RX_ACK;
            end
          end
        TX_BYTE:
          if (w_scl_fall) begin
            r_cnt   <= w_cnt_n;
            r_oe    <= (r_cnt != 3'd7) & ~r_shift[~w_cnt_n];
            r_state <= (r_cnt == 3'd7) ? TX_ACK : TX_BYTE;
          end
        // r_cnt[0] marks a master ACK seen, pending the reload on the next scl_fall
        TX_ACK:
          if (w_scl_rise) begin
            r_state <= w_sda ? IGNORE : TX_ACK;
            tx_req  <= ~w_sda;
            r_cnt   <= {2'b00, ~w_sda};
          end else if (w_scl_fall && r_cnt[0]) begin
            r_state <= TX_BYTE;
            r_shift <= tx_data;
            r_oe    <= ~tx_data[7];
            r_cnt   <= 3'd0;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with a transaction-level model of the target.
// Runs the glitch-filter scenario only when I2C_SLAVE_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_i2c_slave;
  localparam logic [6:0] SA = 7'h50;
  localparam int Q = 10;

  logic clk = 1'b0, rst = 1'b0, scl = 1'b1, m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire sda;
  logic tx_req, rx_valid, rw, busy, done;
  logic [7:0] rx_data;
  int n_cmp = 0, n_err = 0;
  int rx_cnt = 0, tx_cnt = 0, done_cnt = 0, slave_low = 0;
  logic [7:0] rxq[$], tx_src[$], fixed_q[$];
  bit busy_exp = 1'b0;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .tx_data(tx_data), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rw(rw), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters, received-byte capture and tx_data supply
  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      rx_cnt++;
      rxq.push_back(rx_data);
    end
    if (tx_req) begin
      tx_cnt++;
      if (tx_src.size() > 0) tx_data = tx_src.pop_front();
      else tx_data = 8'($urandom);
    end
    if (done) done_cnt++;
    if (!m_low && sda === 1'b0) slave_low++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic wq(input int n = Q);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, output bit seen);
    m_low = ~b; wq();
    scl = 1'b1; wq();
    seen = (sda !== 1'b0); wq();
    scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input bit last, output logic [7:0] b);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(last, s);
    if (last) check("nack_released", s, 1);
  endtask

  task automatic bus_start;
    m_low = 1'b1; wq(); scl = 1'b0; wq();
  endtask

  task automatic bus_restart;
    m_low = 1'b0; wq(); scl = 1'b1; wq(); m_low = 1'b1; wq(); scl = 1'b0; wq();
  endtask

  task automatic bus_stop;
    m_low = 1'b1; wq(); scl = 1'b1; wq(); m_low = 1'b0; wq();
  endtask

  // One addressed segment; a target only responds when the address is its own
  task automatic seg(input bit restart, input logic [6:0] addr, input bit rd, input int n);
    bit hit, a;
    logic [7:0] got;
    logic [7:0] data[$];
    int rx0, tx0, sl0;
    hit = (addr == SA);
    for (int k = 0; k < n; k++)
      if (fixed_q.size() > 0) data.push_back(fixed_q.pop_front());
      else data.push_back(8'($urandom));
    if (hit && rd) tx_src = data;
    else tx_src.delete();
    rxq.delete();
    if (restart) bus_restart();
    else bus_start();
    rx0 = rx_cnt; tx0 = tx_cnt; sl0 = slave_low;
    send_byte({addr, rd}, a);
    check("addr_ack", a, hit);
    check("busy", busy, hit);
    if (hit) check("rw", rw, rd);
    check("tx_req_addr", tx_cnt - tx0, hit && rd);
    for (int k = 0; k < n; k++)
      if (rd) begin
        recv_byte(k == n - 1, got);
        check("rd_data", got, hit ? data[k] : 8'hFF);
      end else begin
        send_byte(data[k], a);
        check("wr_ack", a, hit);
      end
    check("rx_valid_cnt", rx_cnt - rx0, (hit && !rd) ? n : 0);
    check("tx_req_cnt", tx_cnt - tx0, (hit && rd) ? n : 0);
    if (hit && !rd)
      for (int k = 0; k < n; k++) begin
        got = (rxq.size() > 0) ? rxq.pop_front() : ~data[k];
        check("rx_data", got, data[k]);
      end
    if (!hit) check("no_drive", slave_low - sl0, 0);
    busy_exp = hit;
  endtask

  task automatic end_txn;
    int d0;
    d0 = done_cnt;
    bus_stop(); wq();
    check("done_cnt", done_cnt - d0, busy_exp);
    check("busy_idle", busy, 0);
    busy_exp = 1'b0;
  endtask

  initial begin
    bit a;
    logic [7:0] b;
    int segs;
    logic [6:0] ad;
    wq(3);
    check("rst_sda", sda, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_pulses", {rx_valid, tx_req, done}, 0);
    check("rst_rw_busy", {rw, busy}, 0);
    rst = 1'b1; wq();

    fixed_q = '{8'hA5};
    seg(1'b0, SA, 1'b0, 1);
    check("rx_data_a5", rx_data, 8'hA5);
    check("rw_write", rw, 0);
    end_txn();

    fixed_q = '{8'h3C};
    seg(1'b0, SA, 1'b1, 1);
    end_txn();

    seg(1'b0, 7'h51, 1'b0, 1);
    end_txn();

    fixed_q = '{8'h11, 8'h22};
    seg(1'b0, SA, 1'b0, 2);
    seg(1'b1, SA, 1'b1, 1);
    check("rw_restart", rw, 1);
    end_txn();

    // Reset while the target is driving a data ACK
    bus_start();
    send_byte({SA, 1'b0}, a);
    b = 8'hC3;
    for (int i = 7; i >= 0; i--) send_bit(b[i], a);
    m_low = 1'b0; wq();
    check("ack_driven", sda, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_sda", sda, 1);
    check("rst_mid_rx_data", rx_data, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_outs", {rx_valid, tx_req, rw, done}, 0);
    scl = 1'b1; wq();
    rst = 1'b1; wq();
    rxq.delete();
    busy_exp = 1'b0;
    fixed_q = '{8'h5A};
    seg(1'b0, SA, 1'b0, 1);
    check("rx_data_5a", rx_data, 8'h5A);
    end_txn();

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    @(negedge clk); m_low = 1'b1;
    repeat (2) @(negedge clk);
    m_low = 1'b0; wq();
    scl = 1'b0; wq();
    send_byte({SA, 1'b0}, a);
    check("glitch2_no_start", a, 0);
    bus_stop(); wq();
    @(negedge clk); m_low = 1'b1;
    repeat (4) @(negedge clk);
    scl = 1'b0; wq();
    send_byte({SA, 1'b0}, a);
    check("pulse4_start", a, 1);
    busy_exp = 1'b1;
    end_txn();
`endif

    for (int t = 0; t < 12; t++) begin
      segs = $urandom_range(1, 2);
      for (int s = 0; s < segs; s++) begin
        ad = ($urandom_range(0, 1) == 1) ? SA : 7'($urandom);
        seg(s != 0, ad, 1'($urandom), $urandom_range(1, 3));
      end
      end_txn();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
